// File: rtl/gray_rx_decoder.sv
// gray_rx_decoder
//   Receives a Gray-coded value that changes asynchronously to clk. The value is
//   passed through a synchroniser chain and converted back to binary. Each
//   accepted change is classified as an up step, a down step, or an illegal
//   multi-bit jump. The block keeps a wrapping signed position count and a
//   saturating error count.
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   g_in       Gray input (asynchronous to clk)
//   pos_clr    synchronous clear of pos_cnt (wins over a simultaneous step)
//   bin_out    binary value of the last accepted Gray sample
//   step_valid one-cycle pulse for a legal single-bit step
//   step_dir   1 = up, 0 = down; meaningful only with step_valid
//   err        one-cycle pulse for a change of more than one bit
//   locked     set once the first sample after reset has been captured
//   pos_cnt    signed step count, wraps
//   err_cnt    error pulse count, saturates at all-ones
module gray_rx_decoder #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int POS_W       = 8,
  parameter int ERR_W       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        g_in,
  input  logic                    pos_clr,
  output logic [WIDTH-1:0]        bin_out,
  output logic                    step_valid,
  output logic                    step_dir,
  output logic                    err,
  output logic                    locked,
  output logic signed [POS_W-1:0] pos_cnt,
  output logic [ERR_W-1:0]        err_cnt
);

  localparam int PCW = $clog2(SYNC_STAGES + 1);
  localparam int DCW = $clog2(WIDTH + 1);

  typedef enum logic {PRIME, TRACK} state_t;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [DCW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [DCW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + DCW'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH-1:0] g_prev;
  logic [DCW-1:0]   diff_cnt;
  logic             step_up;

  state_t           state, state_nxt;
  logic [PCW-1:0]   prime_cnt, prime_nxt;
  logic             load_en, step_en, err_en, lock_en;

  // Synchroniser chain on the asynchronous Gray input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
    end else begin
      sync_p[0] <= g_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  assign g_s      = sync_p[SYNC_STAGES-1];
  assign b_s      = gray2bin(g_s);
  assign diff_cnt = popcount(g_s ^ g_prev);
  // Up means the new binary value is exactly one more than the held one, modulo 2^WIDTH
  assign step_up  = (b_s == bin_out + WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PRIME;
      prime_cnt <= '0;
    end else begin
      state     <= state_nxt;
      prime_cnt <= prime_nxt;
    end
  end

  // PRIME waits for the chain to hold real samples before the first load;
  // that load only establishes the reference and is never counted.
  always_comb begin
    state_nxt = state;
    prime_nxt = prime_cnt;
    load_en   = 1'b0;
    step_en   = 1'b0;
    err_en    = 1'b0;
    lock_en   = 1'b0;
    case (state)
      PRIME: begin
        if (prime_cnt == PCW'(SYNC_STAGES)) begin
          load_en   = 1'b1;
          lock_en   = 1'b1;
          state_nxt = TRACK;
        end else begin
          prime_nxt = prime_cnt + PCW'(1);
        end
      end
      TRACK: begin
        if (diff_cnt == DCW'(1)) begin
          load_en = 1'b1;
          step_en = 1'b1;
        end else if (diff_cnt != '0) begin
          load_en = 1'b1;
          err_en  = 1'b1;
        end
      end
      default: state_nxt = PRIME;
    endcase
  end

  // Output / counter stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_prev     <= '0;
      bin_out    <= '0;
      step_valid <= 1'b0;
      step_dir   <= 1'b0;
      err        <= 1'b0;
      locked     <= 1'b0;
      pos_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      step_valid <= step_en;
      step_dir   <= step_en & step_up;
      err        <= err_en;
      if (lock_en) locked <= 1'b1;
      if (load_en) begin
        g_prev  <= g_s;
        bin_out <= b_s;
      end
      if (pos_clr) begin
        pos_cnt <= '0;
      end else if (step_en) begin
        pos_cnt <= step_up ? pos_cnt + POS_W'(1) : pos_cnt - POS_W'(1);
      end
      if (err_en) err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_gray_rx_decoder.sv
module tb_gray_rx_decoder;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        g_in = 3'b110;
  logic              pos_clr = 1'b0;
  logic [2:0]        bin_out;
  logic              step_valid, step_dir, err, locked;
  logic signed [7:0] pos_cnt;
  logic [3:0]        err_cnt;

  int checks = 0;
  int errors = 0;
  int nsv = 0, nup = 0, nerr = 0;

  gray_rx_decoder #(.WIDTH(3), .SYNC_STAGES(2), .POS_W(8), .ERR_W(4)) dut (
    .clk(clk), .rst(rst), .g_in(g_in), .pos_clr(pos_clr),
    .bin_out(bin_out), .step_valid(step_valid), .step_dir(step_dir),
    .err(err), .locked(locked), .pos_cnt(pos_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Binary value whose Gray code is g, found by search over the code table
  function automatic int gray_index(input logic [2:0] g);
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = 3'(v);
      if ((vv ^ (vv >> 1)) == g) return v;
    end
    return -1;
  endfunction

  // Reference model: the sample acted on at each edge is the value g_in
  // presented two edges earlier; the first such sample after reset is only loaded.
  logic [2:0]        h1, h2, m_g;
  int                m_n, m_bin, m_ecnt;
  logic              m_locked;
  logic signed [7:0] m_pos;

  always @(posedge clk) begin
    logic e_sv, e_dir, e_err;
    int nb, d;
    e_sv = 0; e_dir = 0; e_err = 0;
    if (rst) begin
      h1 = 0; h2 = 0; m_g = 0; m_n = 0; m_bin = 0; m_ecnt = 0;
      m_locked = 0; m_pos = 0;
    end else begin
      if (!m_locked) begin
        m_n++;
        if (m_n == 3) begin
          m_locked = 1; m_g = h2; m_bin = gray_index(h2);
        end
      end else begin
        d = $countones(h2 ^ m_g);
        nb = gray_index(h2);
        if (d == 1) begin
          e_sv = 1;
          e_dir = (((nb - m_bin) % 8 + 8) % 8) == 1;
          m_pos = e_dir ? m_pos + 8'sd1 : m_pos - 8'sd1;
        end else if (d >= 2) begin
          e_err = 1;
          if (m_ecnt < 15) m_ecnt++;
        end
        if (d != 0) begin
          m_g = h2; m_bin = nb;
        end
      end
      if (pos_clr) m_pos = 0;
      h2 = h1; h1 = g_in;
    end
    #1;
    chk("bin_out", int'(bin_out), m_bin);
    chk("step_valid", int'(step_valid), int'(e_sv));
    if (e_sv) chk("step_dir", int'(step_dir), int'(e_dir));
    chk("err", int'(err), int'(e_err));
    chk("locked", int'(locked), int'(m_locked));
    chk("pos_cnt", int'(pos_cnt), int'(m_pos));
    chk("err_cnt", int'(err_cnt), m_ecnt);
  end

  task automatic apply(input logic [2:0] v, input int hold);
    @(negedge clk);
    g_in = v;
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (step_valid) begin
        nsv++;
        if (step_dir) nup++;
      end
      if (err) nerr++;
    end
  endtask

  initial begin
    logic [2:0] walk [8];
    walk = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

    // Test 1: prime with 110
    repeat (3) @(negedge clk);
    #1;
    chk("rst_locked", int'(locked), 0);
    chk("rst_pos", int'(pos_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("prime_locked_early", int'(locked), 0);
    @(posedge clk);
    #1;
    chk("prime_locked", int'(locked), 1);
    chk("prime_bin", int'(bin_out), 4);
    chk("prime_sv", int'(step_valid), 0);
    chk("prime_err", int'(err), 0);

    // Walk down to 000, then clear position
    apply(3'b010, 4); apply(3'b011, 4); apply(3'b001, 4); apply(3'b000, 4);
    chk("down4_pos", int'(pos_cnt), -4);
    @(negedge clk); pos_clr = 1'b1;
    @(posedge clk); #1;
    chk("clr_pos", int'(pos_cnt), 0);
    @(negedge clk); pos_clr = 1'b0;

    // Test 2: full up walk
    nsv = 0; nup = 0;
    for (int i = 0; i < 8; i++) apply(walk[i], 4);
    chk("walk_nsv", nsv, 8);
    chk("walk_nup", nup, 8);
    chk("walk_pos", int'(pos_cnt), 8);
    chk("walk_bin", int'(bin_out), 0);

    // Test 3: wrap down 0 -> 7
    nsv = 0; nup = 0;
    apply(3'b100, 4);
    chk("wrap_bin", int'(bin_out), 7);
    chk("wrap_nsv", nsv, 1);
    chk("wrap_nup", nup, 0);
    chk("wrap_pos", int'(pos_cnt), 7);
    apply(3'b000, 4);

    // Test 4: illegal jump 000 -> 011
    nsv = 0; nerr = 0;
    apply(3'b011, 4);
    chk("jump_nerr", nerr, 1);
    chk("jump_bin", int'(bin_out), 2);
    chk("jump_errcnt", int'(err_cnt), 1);
    chk("jump_pos", int'(pos_cnt), 8);
    chk("jump_nsv", nsv, 0);

    // Test 5: pos_clr coincident with an up step 011 -> 010
    @(negedge clk); g_in = 3'b010;
    repeat (2) @(posedge clk);
    @(negedge clk); pos_clr = 1'b1;
    @(posedge clk); #1;
    chk("clrstep_pos", int'(pos_cnt), 0);
    chk("clrstep_sv", int'(step_valid), 1);
    chk("clrstep_dir", int'(step_dir), 1);
    chk("clrstep_errcnt", int'(err_cnt), 1);
    @(negedge clk); pos_clr = 1'b0;
    nerr = 0;
    for (int i = 0; i < 16; i++) apply((i % 2 == 0) ? 3'b101 : 3'b010, 4);
    chk("sat_nerr", nerr, 16);
    chk("sat_errcnt", int'(err_cnt), 15);
    chk("sat_pos", int'(pos_cnt), 0);

    // Test 6: reset mid-walk
    apply(3'b110, 4);
    chk("pre_rst_pos", int'(pos_cnt), 1);
    apply(3'b111, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_bin", int'(bin_out), 0);
    chk("arst_locked", int'(locked), 0);
    chk("arst_pos", int'(pos_cnt), 0);
    chk("arst_errcnt", int'(err_cnt), 0);
    chk("arst_sv_err", int'({step_valid, err}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nsv = 0; nerr = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (step_valid) nsv++;
      if (err) nerr++;
    end
    chk("reprime_locked", int'(locked), 1);
    chk("reprime_bin", int'(bin_out), 5);
    chk("reprime_nsv", nsv, 0);
    chk("reprime_nerr", nerr, 0);
    nup = 0;
    apply(3'b101, 4);
    chk("post_bin", int'(bin_out), 6);
    chk("post_pos", int'(pos_cnt), 1);
    chk("post_nup", nup, 1);

    repeat (2) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
